// File: rtl/pad_ctrl_pkg.sv
// Shared defaults and helpers for the pad I/O controller slice.
package pad_ctrl_pkg;

  localparam int PAD_NUM_DEFAULT = 8;
  localparam int PAD_DEB_DEFAULT = 4;

  // Debounce counter width: ceil(log2(deb)), never below one bit.
  function automatic int cnt_width(input int deb);
    return (deb > 1) ? $clog2(deb) : 1;
  endfunction

endpackage

// File: rtl/pad_in_filter.sv
// One pad input lane: 2-flop synchronizer, optional debounce, and
// registered rise/fall pulses aligned with the new filtered level.
module pad_in_filter
  import pad_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = PAD_DEB_DEFAULT
) (
  input  logic axis_clk,
  input  logic axis_rst_n,
  input  logic pad_c,
  input  logic filt_en,
  output logic core_in,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int            CW      = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          core_nxt;

  // Any cycle where s agrees with core_in (or bypass) leaves cnt at zero.
  always_comb begin
    core_nxt = core_in;
    cnt_nxt  = '0;
    if (!filt_en) begin
      core_nxt = s;
    end else if (s != core_in) begin
      if (cnt == CNT_MAX) core_nxt = s;
      else                cnt_nxt  = cnt + 1'b1;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      sync1    <= 1'b0;
      s        <= 1'b0;
      core_in  <= 1'b0;
      cnt      <= '0;
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
    end else begin
      sync1    <= pad_c;
      s        <= sync1;
      core_in  <= core_nxt;
      cnt      <= cnt_nxt;
      rise_evt <= core_nxt & ~core_in;
      fall_evt <= ~core_nxt & core_in;
    end
  end

endmodule

// File: rtl/pad_io_ctrl.sv
// Bidirectional pad controller: registered pad drive controls plus one
// filtered input lane per pad.
module pad_io_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int NUM_PADS   = PAD_NUM_DEFAULT,
  parameter int DEB_CYCLES = PAD_DEB_DEFAULT
) (
  input  logic                axis_clk,
  input  logic                axis_rst_n,
  input  logic [NUM_PADS-1:0] pad_c,
  output logic [NUM_PADS-1:0] pad_i,
  output logic [NUM_PADS-1:0] pad_oen,
  output logic [NUM_PADS-1:0] pad_ren,
  input  logic [NUM_PADS-1:0] core_out,
  input  logic [NUM_PADS-1:0] core_oe,
  input  logic [NUM_PADS-1:0] core_pull,
  input  logic                filt_en,
  output logic [NUM_PADS-1:0] core_in,
  output logic [NUM_PADS-1:0] rise_evt,
  output logic [NUM_PADS-1:0] fall_evt
);

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    pad_in_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filt (
      .axis_clk  (axis_clk),
      .axis_rst_n(axis_rst_n),
      .pad_c     (pad_c[g]),
      .filt_en   (filt_en),
      .core_in   (core_in[g]),
      .rise_evt  (rise_evt[g]),
      .fall_evt  (fall_evt[g])
    );
  end

  // Reset leaves every pad tristated with pulls off.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      pad_i   <= '0;
      pad_oen <= '1;
      pad_ren <= '1;
    end else begin
      pad_i   <= core_out;
      pad_oen <= ~core_oe;
      pad_ren <= ~core_pull;
    end
  end

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Scoreboard bench for pad_io_ctrl (4 pads, 4-cycle debounce) with a
// history-window reference model.
module tb_pad_io_ctrl;

  localparam int NP  = 4;
  localparam int DEB = 4;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n;
  logic [NP-1:0] pad_c, pad_i, pad_oen, pad_ren;
  logic [NP-1:0] core_out, core_oe, core_pull;
  logic          filt_en;
  logic [NP-1:0] core_in, rise_evt, fall_evt;

  pad_io_ctrl #(.NUM_PADS(NP), .DEB_CYCLES(DEB)) dut (
    .axis_clk  (axis_clk),
    .axis_rst_n(axis_rst_n),
    .pad_c     (pad_c),
    .pad_i     (pad_i),
    .pad_oen   (pad_oen),
    .pad_ren   (pad_ren),
    .core_out  (core_out),
    .core_oe   (core_oe),
    .core_pull (core_pull),
    .filt_en   (filt_en),
    .core_in   (core_in),
    .rise_evt  (rise_evt),
    .fall_evt  (fall_evt)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct packed {
    logic [NP-1:0] core, rise, fall, pi, poe, pre;
  } exp_t;
  typedef struct packed {
    logic [NP-1:0] s;
    logic          f;
  } hist_t;

  exp_t  sb[$];
  hist_t hist[$];
  int    total = 0;
  int    bad   = 0;

  // Reference state: pad samples in flight and the filtered level.
  logic [NP-1:0] m_p1, m_p2, m_core;

  task automatic chk(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A filtered level flips only when the last DEB sampled levels were all
  // taken with filtering on and all disagreed with it; bypass copies s.
  task automatic model_edge();
    exp_t          e;
    logic [NP-1:0] s, nv;
    bit            ok;
    if (!axis_rst_n) begin
      m_p1 = '0; m_p2 = '0; m_core = '0;
      hist.delete();
      e = '{core: '0, rise: '0, fall: '0, pi: '0, poe: '1, pre: '1};
    end else begin
      s = m_p2;
      hist.push_back('{s: s, f: filt_en});
      if (hist.size() > DEB) void'(hist.pop_front());
      nv = m_core;
      for (int n = 0; n < NP; n++) begin
        if (!filt_en) nv[n] = s[n];
        else begin
          ok = (hist.size() == DEB);
          foreach (hist[i]) if (!hist[i].f || hist[i].s[n] == m_core[n]) ok = 0;
          if (ok) nv[n] = s[n];
        end
      end
      e.core = nv;
      e.rise = nv & ~m_core;
      e.fall = ~nv & m_core;
      e.pi   = core_out;
      e.poe  = ~core_oe;
      e.pre  = ~core_pull;
      m_core = nv;
      m_p2   = m_p1;
      m_p1   = pad_c;
    end
    sb.push_back(e);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge axis_clk);
      model_edge();
      @(negedge axis_clk);
    end
  endtask

  task automatic assert_reset_check();
    axis_rst_n = 1'b0;
    #1;
    chk("rst_async_core_in", core_in, '0);
    chk("rst_async_rise", rise_evt, '0);
    chk("rst_async_fall", fall_evt, '0);
    chk("rst_async_pad_i", pad_i, '0);
    chk("rst_async_pad_oen", pad_oen, '1);
    chk("rst_async_pad_ren", pad_ren, '1);
  endtask

  // Monitor: compares each registered update against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge axis_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("core_in", core_in, e.core);
        chk("rise_evt", rise_evt, e.rise);
        chk("fall_evt", fall_evt, e.fall);
        chk("pad_i", pad_i, e.pi);
        chk("pad_oen", pad_oen, e.poe);
        chk("pad_ren", pad_ren, e.pre);
      end
    end
  end

  initial begin
    int lat;
    int waited;
    axis_rst_n = 1'b1;
    pad_c = '0; core_out = '0; core_oe = 4'hF; core_pull = '0; filt_en = 1'b1;
    @(negedge axis_clk);
    assert_reset_check();
    step(3);
    axis_rst_n = 1'b1;
    step(5);

    // Clean rising edge on pad 0: pulse expected after the 6th edge.
    pad_c[0] = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (rise_evt[0] && lat < 0) lat = i;
    end
    chk_int("clean_edge_latency", lat, DEB + 2);

    // Glitches on pad 1: 3 cycles are swallowed, 4 cycles get through.
    pad_c[1] = 1'b1; step(3); pad_c[1] = 1'b0; step(8);
    chk("glitch3_core_in1", {3'b0, core_in[1]}, 4'b0);
    pad_c[1] = 1'b1; step(4); pad_c[1] = 1'b0; step(10);

    // Bypass.
    filt_en = 1'b0; pad_c = 4'b1010; step(5);
    chk("bypass_core_in", core_in, 4'b1010);
    filt_en = 1'b1; step(2);

    // Output path.
    core_out = 4'b0110; core_oe = 4'b0011; core_pull = 4'b1000; step(2);

    // Mid-count reset.
    pad_c = 4'b0000; step(8);
    pad_c[2] = 1'b1; step(4);
    assert_reset_check();
    step();
    axis_rst_n = 1'b1;
    step(10);

    // Mid-count filt_en 1->0->1.
    pad_c = 4'b0000; step(8);
    pad_c[3] = 1'b1; step(4);
    filt_en = 1'b0; step();
    filt_en = 1'b1; pad_c[3] = 1'b0; step(10);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NP; b++)
        if ($urandom_range(0, 7) == 0) pad_c[b] = ~pad_c[b];
      core_out  = NP'($urandom);
      core_oe   = NP'($urandom);
      core_pull = NP'($urandom);
      if ($urandom_range(0, 63) == 0) filt_en = ~filt_en;
      if ($urandom_range(0, 499) == 0) begin
        assert_reset_check();
        step();
        axis_rst_n = 1'b1;
      end else begin
        step();
      end
    end

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(negedge axis_clk);
      waited++;
    end
    chk_int("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pad_io_ctrl.md
PAD_IO_CTRL -- requirements
Module: pad_io_ctrl

Interface
REQ-001 SHALL have parameter NUM_PADS, default 8, number of bidirectional pad channels (1..32).
REQ-002 SHALL have parameter DEB_CYCLES, default 4, consecutive mismatch cycles before the filtered input changes (1..255).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: axis_clk  input  1  block clock; axis_rst_n  input  1  async active-low reset.
REQ-004 SHALL have port pad_c  input  NUM_PADS  raw level from pad C pins (asynchronous to axis_clk).
REQ-005 SHALL have port pad_i  output  NUM_PADS  drive data to pad I pins.
REQ-006 SHALL have port pad_oen  output  NUM_PADS  pad output enable, active-low (1 = tristate).
REQ-007 SHALL have port pad_ren  output  NUM_PADS  pad pull enable, active-low.
REQ-008 SHALL have ports core_out  input  NUM_PADS  data to drive; core_oe  input  NUM_PADS  1 = drive pad; core_pull  input  NUM_PADS  1 = enable pull.
REQ-009 SHALL have port filt_en  input  1  1 = debounce active, 0 = bypass.
REQ-010 SHALL have ports core_in  output  NUM_PADS  synchronized/filtered pad level; rise_evt  output  NUM_PADS  one-cycle rising pulse; fall_evt  output  NUM_PADS  one-cycle falling pulse.

Function
REQ-011 Each pad_c bit SHALL pass through a 2-flop synchronizer; the second-stage output is the synced level s.
REQ-012 With filt_en=1, per pad: if s != core_in and cnt == DEB_CYCLES-1 then core_in <= s, cnt <= 0; else if s != core_in then cnt <= cnt+1; else cnt <= 0.
REQ-013 Any single-cycle return of s to core_in SHALL clear cnt (a glitch shorter than DEB_CYCLES cycles never reaches core_in).
REQ-014 With filt_en=0, core_in <= s every cycle and all cnt SHALL be held at 0.
REQ-015 Latency: a pad level stable before rising edge k SHALL appear on core_in after edge k+1+DEB_CYCLES (filtered) or edge k+2 (bypass); DEB_CYCLES=1 equals bypass timing.
REQ-016 rise_evt[n]/fall_evt[n] SHALL be registered and asserted for exactly the one cycle in which core_in[n] has just transitioned 0->1 / 1->0, coincident with the new core_in value.
REQ-017 filt_en changing mid-count SHALL take effect on the next edge; a pending count SHALL be discarded on 1->0, and counting SHALL restart from 0 on 0->1.
REQ-018 pad_i <= core_out, pad_oen <= ~core_oe, pad_ren <= ~core_pull, all registered with 1-cycle latency, independent per pad.
REQ-019 The counter width SHALL be ceil(log2(DEB_CYCLES)) bits, minimum 1; cnt SHALL never exceed DEB_CYCLES-1 (no wrap).
REQ-020 Pads SHALL be fully independent; simultaneous events on multiple pads SHALL each produce their own pulse in the same cycle.

Reset
REQ-021 On axis_rst_n=0 (asynchronous): synchronizer flops, core_in, cnt, rise_evt, fall_evt, pad_i = 0; pad_oen = all 1 (tristate); pad_ren = all 1 (pull off).
REQ-022 Release SHALL be synchronous to axis_clk; a pad held high through reset SHALL produce one rise_evt at its normal latency after release.
REQ-023 Reset asserted mid-count SHALL discard the count; no event pulse SHALL appear during or on the first edge after reset.

Structure
REQ-024 Defaults PAD_NUM_DEFAULT=8 and PAD_DEB_DEFAULT=4 SHALL live in the shared package pad_ctrl_pkg.
REQ-025 Per-pad synchronizer + debounce + edge logic SHALL be sub-module pad_in_filter (1 bit), instantiated NUM_PADS times via generate; output registers SHALL remain in pad_io_ctrl.

Verification (NUM_PADS=4, DEB_CYCLES=4, filt_en=1 unless stated)
REQ-026 Reset check: assert axis_rst_n=0 with core_oe=4'hF -> pad_oen=4'hF, pad_ren=4'hF, core_in=0, no events until release.
REQ-027 Clean edge: pad_c[0] 0->1 before edge 10 -> core_in[0]=1 and rise_evt[0]=1 for one cycle after edge 15 only.
REQ-028 Glitch: pad_c[1] high for 3 cycles then low -> core_in[1] stays 0, no rise_evt; 4 cycles high -> rise_evt[1] after edge k+5.
REQ-029 Bypass: filt_en=0, pad_c=4'b1010 before edge k -> core_in=4'b1010 after edge k+2, rise_evt=4'b1010 for one cycle.
REQ-030 Output path: core_out=4'b0110, core_oe=4'b0011, core_pull=4'b1000 at edge k -> after edge k pad_i=4'b0110, pad_oen=4'b1100, pad_ren=4'b0111.
REQ-031 Mid-count disturbances: reset pulse, or filt_en 1->0->1, after 2 mismatch cycles -> count discarded, update occurs 4 full cycles after the restart.
